// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-to-1 select stage behind a 2-entry skid buffer.
// The selected input enters the main register, or the skid register while
// the consumer stalls. ready_o depends only on registered state. Beats whose
// select is out of range complete their handshake but are dropped, and they
// are counted in a saturating error counter.
module mux_nto1_pipe #(
  parameter int SIZE  = 32,
  parameter int NUM   = 3,
  parameter int SEL_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]    select_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [SIZE-1:0]     data_o,
  output logic                valid_o,
  input  logic                ready_i,
  input  logic                flush_i,
  output logic                sel_err_o,
  output logic [7:0]          err_cnt_o
);

  generate
    if (NUM < 2 || NUM > 16 || (2 ** SEL_W) < NUM) begin : g_param_check
      $error("mux_nto1_pipe: NUM must be 2..16 and 2**SEL_W >= NUM");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [SEL_W:0] NUM_L = (SEL_W + 1)'(NUM);

  state_e          state_q, state_d;
  logic [SIZE-1:0] main_q, main_d;
  logic [SIZE-1:0] skid_q, skid_d;
  logic            sel_err_q, sel_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [SIZE-1:0] sel_data;
  logic            in_range;
  logic            hs;
  logic            acc;
  logic            bad;
  logic            tx;

  // Select the addressed input; out-of-range selects produce zero (never stored)
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (select_i == SEL_W'(k)) sel_data = data_i[k*SIZE +: SIZE];
    end
  end

  assign in_range = ({1'b0, select_i} < NUM_L);
  assign ready_o  = (state_q != FULL);
  assign valid_o  = (state_q != EMPTY);
  assign data_o   = main_q;
  assign sel_err_o = sel_err_q;
  assign err_cnt_o = err_cnt_q;

  // A flush swallows any beat offered in the same cycle, including bad selects
  assign hs  = valid_i && ready_o && !flush_i;
  assign acc = hs && in_range;
  assign bad = hs && !in_range;
  assign tx  = valid_o && ready_i;

  // Next-state, buffer data and error bookkeeping
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    sel_err_d = bad;
    err_cnt_d = err_cnt_q;
    if (bad && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = sel_data;
          end
        end
        ONE: begin
          if (acc && tx) begin
            main_d = sel_data;
          end else if (acc) begin
            state_d = FULL;
            skid_d  = sel_data;
          end else if (tx) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (tx) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and data registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      sel_err_q <= sel_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
Parametrised N-to-1 selection stage for the pipelined datapath. It is the registered, handshaked successor of the fixed 3-input combinational muxes. It selects one of NUM packed inputs and passes the result through a 2-entry skid buffer with valid/ready flow control, synchronous flush and out-of-range select detection. It sits between a pipeline stage and its consumer, for example on forwarding or write-back paths where stalls must not drop data.

Parameters:
SIZE, 32, data width of each input and of the output
NUM, 3, number of inputs, legal range 2..16
SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM (elaboration check)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
data_i  input  NUM*SIZE  packed inputs; input k occupies bits [k*SIZE +: SIZE]
select_i  input  SEL_W  index of the input to pass
valid_i  input  1  upstream beat present
ready_o  output  1  block can accept a beat this cycle
data_o  output  SIZE  head-of-buffer data
valid_o  output  1  data_o valid
ready_i  input  1  downstream accepts data_o this cycle
flush_i  input  1  synchronous clear of all buffered beats
sel_err_o  output  1  one-cycle pulse: a beat with select_i >= NUM was accepted
err_cnt_o  output  8  saturating count of out-of-range beats

Behaviour:
- Reset (async, rst_i=1): both entries invalid; data_o=0, valid_o=0, sel_err_o=0, err_cnt_o=0. ready_o=1 while in reset and after release.
- Handshake:
  - Input accepted when valid_i && ready_o.
  - Output transfers when valid_o && ready_i.
  - data_o and valid_o hold stable while valid_o && !ready_i.
- Storage:
  - Main register (drives data_o/valid_o) plus one skid register.
  - ready_o = !skid_valid. It is a pure function of registered state; there is no combinational path from ready_i.
- States:
  - EMPTY (main invalid)
  - ONE (main valid, skid invalid)
  - FULL (both valid)
- Transitions (acc = accepted in-range beat, tx = output transfer):
  - EMPTY: acc -> ONE, main <= selected data.
  - ONE: acc && tx -> ONE, main <= new. acc && !tx -> FULL, skid <= new. !acc && tx -> EMPTY. Otherwise hold.
  - FULL: ready_o=0, no acceptance. tx -> ONE, main <= skid, skid invalid. Otherwise hold.
- Latency: an accepted beat appears on data_o the next cycle when the block was EMPTY, or ONE with tx in the same cycle. Throughput is 1 beat/cycle with ready_i held high.
- Ordering: strict FIFO; no beat is duplicated or lost except by flush or an out-of-range select.
- Out-of-range select (select_i >= NUM, only possible when NUM < 2^SEL_W):
  - The beat is consumed (handshake completes) but not stored.
  - sel_err_o=1 in the next cycle only.
  - err_cnt_o increments and saturates at 255.
  - State is otherwise unchanged, as if valid_i were 0.
- Flush (flush_i=1 at a clock edge):
  - Both entries invalid; valid_o=0 the next cycle.
  - Any beat offered the same cycle is discarded and does not raise sel_err_o.
  - err_cnt_o is not cleared; only rst_i clears it.
  - Flush has priority over accept and transfer.
- data_o when valid_o=0 is don't-care; implementation holds the last value (0 after reset).
- Reset asserted mid-operation discards all beats immediately (asynchronously).

Test Plan:
- Basic pass: NUM=3, SIZE=32, ready_i=1; inputs {0x11,0x22,0x33}, select 0,1,2 on 3 consecutive beats -> data_o 0x11,0x22,0x33 on cycles 1,2,3 after each accept; valid_o continuous; ready_o always 1.
- Backpressure/skid: ready_i=0, send beats A=0xA, B=0xB -> state FULL, ready_o=0 after the 2nd accept, data_o=0xA held. Raise ready_i -> 0xA then 0xB on consecutive cycles; ready_o returns to 1 one cycle after the first transfer.
- Out-of-range: NUM=3, select_i=3 with valid_i=1 -> accepted (ready_o=1), valid_o stays 0, sel_err_o pulses 1 for one cycle, err_cnt_o=1. Send 300 such beats -> err_cnt_o=255.
- Flush in FULL with valid_i=1: buffer holds 2 beats, assert flush_i -> next cycle valid_o=0, ready_o=1, offered beat absent, err_cnt_o unchanged.
- Async reset mid-stream: assert rst_i between clock edges while FULL -> valid_o=0, data_o=0, err_cnt_o=0 immediately. After release, the first accepted beat appears 1 cycle later.
- Wide config: NUM=16, SIZE=8, random select/valid/ready for 10k cycles -> output sequence matches a reference queue, no loss or duplication.
